// File: rtl/tick_capture_pkg.sv
// Shared types and constants for the tick interval capture block.
// The interval counter saturates at all-ones; satMax gives that value for a
// given counter width so every user computes it the same way.
package tick_capture_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // All-ones value for a counter of width w (valid for w < 64).
    function automatic logic [63:0] satMax(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/event_sync_edge.sv
// Event input conditioning: optional two-flop synchronizer, one history flop,
// and a single-cycle rising-edge pulse.
// Build option: CAPTURE_SYNC_EN adds the synchronizer so event_i may be
// asynchronous to clk. Without it event_i is registered once and must be
// synchronous to clk; edge detection is then one cycle earlier.
module event_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic event_i,
    output logic rise_o
);

    logic level;
    logic hist_q;

`ifdef CAPTURE_SYNC_EN
    logic meta_q;
    logic sync_q;

    // Two-flop synchronizer so an asynchronous event cannot go metastable downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= event_i;
            sync_q <= meta_q;
        end
    end

    assign level = sync_q;
`else
    logic evt_q;

    // Single input register; the event is already synchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= event_i;
        end
    end

    assign level = evt_q;
`endif

    // History of the conditioned level, used to spot the low-to-high step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= level;
        end
    end

    assign rise_o = level & ~hist_q;

endmodule

// File: rtl/tick_interval_capture.sv
// Counts timebase ticks between successive rising edges of event_in and
// presents each completed interval on a one-deep valid/ready slot.
// Build option: CAPTURE_SYNC_EN (see event_sync_edge) synchronizes event_in.
module tick_interval_capture
    import tick_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             event_in,
    output logic [CNT_W-1:0] cap_data,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic             cap_ovf,
    output logic             missed,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(satMax(CNT_W));

    logic             rise;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             ovf_q,       ovf_d;
    logic [CNT_W-1:0] cap_data_q,  cap_data_d;
    logic             cap_valid_q, cap_valid_d;
    logic             cap_ovf_q,   cap_ovf_d;
    logic             missed_q,    missed_d;

    logic [CNT_W-1:0] incCount;
    logic             incOvf;

    event_sync_edge u_edge (
        .clk     (clk),
        .reset   (reset),
        .event_i (event_in),
        .rise_o  (rise)
    );

    // State, interval counter and output slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            cap_ovf_q   <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            cap_ovf_q   <= cap_ovf_d;
            missed_q    <= missed_d;
        end
    end

    // Next-state logic: a tick in the edge cycle belongs to the closing
    // interval, so captures use the already-incremented count.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cap_data_d  = cap_data_q;
        cap_valid_d = cap_valid_q;
        cap_ovf_d   = cap_ovf_q;
        missed_d    = missed_q;

        incCount = (tick && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;
        incOvf   = ovf_q | (incCount == CNT_MAX);

        if (cap_valid_q && cap_ready) begin
            cap_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (!cap_valid_q || cap_ready) begin
                        cap_data_d  = incCount;
                        cap_ovf_d   = incOvf;
                        cap_valid_d = 1'b1;
                    end else begin
                        missed_d = 1'b1;
                    end
                end else begin
                    count_d = incCount;
                    ovf_d   = incOvf;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cap_data  = cap_data_q;
    assign cap_valid = cap_valid_q;
    assign cap_ovf   = cap_ovf_q;
    assign missed    = missed_q;
    assign armed     = (state_q == MEASURE);

endmodule

// File: tb/tb_tick_interval_capture.sv
// Directed testbench for tick_interval_capture, built with a 4-bit counter so
// saturation is reachable in a few cycles. Honours CAPTURE_SYNC_EN for the
// expected edge latency.
module tb_tick_interval_capture;

    localparam int CNT_W = 4;
`ifdef CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             event_in = 1'b0;
    logic             cap_ready = 1'b0;
    logic [CNT_W-1:0] cap_data;
    logic             cap_valid;
    logic             cap_ovf;
    logic             missed;
    logic             armed;

    int checks = 0;
    int errors = 0;

    tick_interval_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .event_in  (event_in),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_ovf   (cap_ovf),
        .missed    (missed),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply n consecutive single-cycle ticks.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            stepCycle();
        end
        tick = 1'b0;
    endtask

    // Raise event_in and wait until the edge has acted on the DUT registers;
    // withTick places a tick on the very edge where the edge is acted upon.
    task automatic riseEdge(input bit withTick);
        event_in = 1'b1;
        repeat (LAT) stepCycle();
        tick = withTick;
        stepCycle();
        tick = 1'b0;
    endtask

    task automatic fallEdge();
        event_in = 1'b0;
        repeat (3) stepCycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"},   32'(cap_data),  0);
        checkOutput({tag, "_valid"},  32'(cap_valid), 0);
        checkOutput({tag, "_ovf"},    32'(cap_ovf),   0);
        checkOutput({tag, "_missed"}, 32'(missed),    0);
        checkOutput({tag, "_armed"},  32'(armed),     0);
    endtask

    initial begin
        $display("[TB] start, edge latency %0d", LAT);

        // Reset state
        repeat (2) stepCycle();
        checkAllZero("rst");
        reset = 1'b0;
        cap_ready = 1'b1;
        stepCycle();

        // First edge arms only; 5 ticks then capture
        riseEdge(1'b0);
        checkOutput("arm_armed", 32'(armed), 1);
        checkOutput("arm_valid", 32'(cap_valid), 0);
        fallEdge();
        applyStimulus(5);
        checkOutput("t1_armed_mid", 32'(armed), 1);
        riseEdge(1'b0);
        checkOutput("t1_valid", 32'(cap_valid), 1);
        checkOutput("t1_data", 32'(cap_data), 5);
        checkOutput("t1_ovf", 32'(cap_ovf), 0);
        checkOutput("t1_armed", 32'(armed), 1);
        stepCycle();
        checkOutput("t1_valid_fall", 32'(cap_valid), 0);
        fallEdge();

        // Tick coincident with the closing edge
        applyStimulus(3);
        riseEdge(1'b1);
        checkOutput("t2_data", 32'(cap_data), 4);
        checkOutput("t2_valid", 32'(cap_valid), 1);
        stepCycle();
        fallEdge();
        applyStimulus(2);
        riseEdge(1'b0);
        checkOutput("t2b_data", 32'(cap_data), 2);
        stepCycle();
        fallEdge();

        // Saturation and overflow flag
        applyStimulus(20);
        riseEdge(1'b0);
        checkOutput("sat_data", 32'(cap_data), 15);
        checkOutput("sat_ovf", 32'(cap_ovf), 1);
        stepCycle();
        fallEdge();
        applyStimulus(14);
        riseEdge(1'b0);
        checkOutput("b14_data", 32'(cap_data), 14);
        checkOutput("b14_ovf", 32'(cap_ovf), 0);
        stepCycle();
        fallEdge();
        applyStimulus(15);
        riseEdge(1'b0);
        checkOutput("b15_data", 32'(cap_data), 15);
        checkOutput("b15_ovf", 32'(cap_ovf), 1);
        stepCycle();
        fallEdge();
        applyStimulus(3);
        riseEdge(1'b0);
        checkOutput("post_sat_data", 32'(cap_data), 3);
        checkOutput("post_sat_ovf", 32'(cap_ovf), 0);
        stepCycle();
        fallEdge();

        // Back-pressure: slot full drops later captures
        cap_ready = 1'b0;
        applyStimulus(2);
        riseEdge(1'b0);
        checkOutput("bp1_valid", 32'(cap_valid), 1);
        checkOutput("bp1_data", 32'(cap_data), 2);
        checkOutput("bp1_missed", 32'(missed), 0);
        fallEdge();
        applyStimulus(3);
        riseEdge(1'b0);
        checkOutput("bp2_data", 32'(cap_data), 2);
        checkOutput("bp2_missed", 32'(missed), 1);
        fallEdge();
        applyStimulus(4);
        riseEdge(1'b0);
        checkOutput("bp3_data", 32'(cap_data), 2);
        checkOutput("bp3_valid", 32'(cap_valid), 1);
        fallEdge();
        cap_ready = 1'b1;
        stepCycle();
        checkOutput("bp_drain_valid", 32'(cap_valid), 0);
        checkOutput("bp_drain_missed", 32'(missed), 1);

        // Capture while the slot is consumed in the same cycle
        cap_ready = 1'b0;
        applyStimulus(1);
        riseEdge(1'b0);
        checkOutput("rl1_data", 32'(cap_data), 1);
        fallEdge();
        applyStimulus(6);
        event_in = 1'b1;
        repeat (LAT) stepCycle();
        cap_ready = 1'b1;
        stepCycle();
        checkOutput("rl2_valid", 32'(cap_valid), 1);
        checkOutput("rl2_data", 32'(cap_data), 6);
        stepCycle();
        checkOutput("rl2_valid_fall", 32'(cap_valid), 0);
        fallEdge();

        // Reset in the middle of an interval
        applyStimulus(7);
        reset = 1'b1;
        stepCycle();
        checkAllZero("midrst");
        reset = 1'b0;
        stepCycle();
        riseEdge(1'b0);
        checkOutput("rearm_armed", 32'(armed), 1);
        checkOutput("rearm_valid", 32'(cap_valid), 0);
        fallEdge();
        applyStimulus(2);
        riseEdge(1'b0);
        checkOutput("rearm_data", 32'(cap_data), 2);
        stepCycle();
        fallEdge();

        // Edge latency measured on armed
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        stepCycle();
        event_in = 1'b1;
        stepCycle();
        checkOutput("lat_edgeN", 32'(armed), 0);
`ifdef CAPTURE_SYNC_EN
        stepCycle();
        checkOutput("lat_edgeN1", 32'(armed), 0);
`endif
        stepCycle();
        checkOutput("lat_armed", 32'(armed), 1);
        stepCycle();
        fallEdge();
        riseEdge(1'b0);
        checkOutput("zero_valid", 32'(cap_valid), 1);
        checkOutput("zero_data", 32'(cap_data), 0);
        stepCycle();
        fallEdge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
